// File: rtl/y86_decode_regid.sv
// y86_decode_regid: decode-stage register IDs (srcA/srcB/destE/destM) for the pipelined Y86-64, registered once per clock.
module y86_decode_regid #(
   parameter logic [3:0] RNONE = 4'hF,
   parameter logic [3:0] RRSP  = 4'h4
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [3:0] icode_i,
   input  logic       cnd_i,
   input  logic [3:0] ra_i,
   input  logic [3:0] rb_i,
   output logic [3:0] srca_o,
   output logic [3:0] srcb_o,
   output logic [3:0] destm_o,
   output logic [3:0] deste_o
);
   logic [3:0] srca_d, srcb_d, destm_d, deste_d;
   logic [3:0] srca_q, srcb_q, destm_q, deste_q;
   always_comb begin
      srca_d  = (icode_i inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra_i :
                (icode_i inside {4'h9, 4'hB}) ? RRSP : RNONE;
      srcb_d  = (icode_i inside {4'h4, 4'h5, 4'h6}) ? rb_i :
                (icode_i inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RRSP : RNONE;
      // cmovXX writes back only when the condition holds
      deste_d = (icode_i == 4'h2) ? (cnd_i ? rb_i : RNONE) :
                (icode_i inside {4'h3, 4'h6}) ? rb_i :
                (icode_i inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RRSP : RNONE;
      destm_d = (icode_i inside {4'h5, 4'hB}) ? ra_i : RNONE;
   end
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         srca_q  <= RNONE;
         srcb_q  <= RNONE;
         destm_q <= RNONE;
         deste_q <= RNONE;
      end else begin
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         destm_q <= destm_d;
         deste_q <= deste_d;
      end
   end
   assign srca_o  = srca_q;
   assign srcb_o  = srcb_q;
   assign destm_o = destm_q;
   assign deste_o = deste_q;
endmodule

// File: tb/tb_y86_decode_regid.sv
// tb_y86_decode_regid: directed plan plus random stimulus checked against a per-instruction reference table.
module tb_y86_decode_regid;
   localparam logic [3:0] NONE = 4'hF;
   localparam logic [3:0] RSP  = 4'h4;
   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] icode, ra, rb;
   logic       cnd;
   logic [3:0] srca, srcb, destm, deste;
   int         errors = 0;
   int         checks = 0;
   logic [15:0] exp_v;

   y86_decode_regid dut (
      .clock_i(clock), .reset_i(reset), .icode_i(icode), .cnd_i(cnd),
      .ra_i(ra), .rb_i(rb), .srca_o(srca), .srcb_o(srcb),
      .destm_o(destm), .deste_o(deste)
   );

   always #5 clock = ~clock;

   // Reference: what each instruction reads and writes, as {srcA, srcB, destE, destM}
   function automatic logic [15:0] model(input logic [3:0] ic, input logic c,
                                         input logic [3:0] a, input logic [3:0] b);
      case (ic)
         4'h2: return {a, NONE, (c ? b : NONE), NONE};
         4'h3: return {NONE, NONE, b, NONE};
         4'h4: return {a, b, NONE, NONE};
         4'h5: return {NONE, b, NONE, a};
         4'h6: return {a, b, b, NONE};
         4'h8: return {NONE, RSP, RSP, NONE};
         4'h9: return {RSP, RSP, RSP, NONE};
         4'hA: return {a, RSP, RSP, NONE};
         4'hB: return {RSP, RSP, RSP, a};
         default: return {NONE, NONE, NONE, NONE};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] e);
      chk({tag, ".srcA"},  srca,  e[15:12]);
      chk({tag, ".srcB"},  srcb,  e[11:8]);
      chk({tag, ".destE"}, deste, e[7:4]);
      chk({tag, ".destM"}, destm, e[3:0]);
   endtask

   task automatic step(input string tag, input logic r, input logic [3:0] ic,
                       input logic c, input logic [3:0] a, input logic [3:0] b);
      reset = r; icode = ic; cnd = c; ra = a; rb = b;
      @(posedge clock);
      #1;
      chk_all(tag, r ? 16'hFFFF : model(ic, c, a, b));
   endtask

   initial begin
      step("reset", 1'b1, 4'hB, 1'b0, 4'h2, 4'h7);
      chk_all("reset_lit", 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         step("popq", 1'b0, 4'hB, 1'b0, 4'h2, 4'h7);
         chk_all("popq_lit", 16'h4442);
      end
      step("cmov_t", 1'b0, 4'h2, 1'b1, 4'h3, 4'h5);
      chk_all("cmov_t_lit", 16'h3F5F);
      step("cmov_f", 1'b0, 4'h2, 1'b0, 4'h3, 4'h5);
      chk_all("cmov_f_lit", 16'h3FFF);
      step("opq", 1'b0, 4'h6, 1'b0, 4'h1, 4'h2);
      chk_all("opq_lit", 16'h122F);
      step("mrmov", 1'b0, 4'h5, 1'b1, 4'h6, 4'h7);
      chk_all("mrmov_lit", 16'hF7F6);
      step("push", 1'b0, 4'hA, 1'b1, 4'h9, 4'h3);
      chk_all("push_lit", 16'h944F);
      foreach (exp_v[i]) if (i < 7) begin
         logic [3:0] ics [7];
         ics = '{4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
         step("noreg", 1'b0, ics[i], 1'b1, 4'h1, 4'h2);
         chk_all("noreg_lit", 16'hFFFF);
      end
      // latency: inputs change between edges, outputs must hold until the edge
      step("irmov", 1'b0, 4'h3, 1'b0, 4'h1, 4'h2);
      icode = 4'h8;
      #3;
      chk_all("hold", 16'hFF2F);
      @(posedge clock);
      #1;
      chk_all("call", 16'hF44F);
      for (int n = 0; n < 300; n++) begin
         logic [3:0] ric, rra, rrb;
         logic rc, rr;
         ric = 4'($urandom); rra = 4'($urandom); rrb = 4'($urandom);
         rc = 1'($urandom); rr = ($urandom_range(0, 15) == 0);
         step("rand", rr, ric, rc, rra, rrb);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/y86_decode_regid.md
Name: y86_decode_regid

Overview:
- Register-ID generation for the decode stage of the pipelined Y86-64 processor.
- From the decode-stage instruction fields (icode, rA, rB) and the condition flag Cnd, produces:
  - the two register-file read addresses (srcA, srcB);
  - the two write-back destination IDs (destE, destM).
- Outputs are registered once per clock.
- Sits between the fetch/decode pipeline register and the register file / execute pipeline register.

Parameters:
- RNONE, 4'hF, register ID meaning "no register".
- RRSP, 4'h4, register ID of %rsp (stack pointer).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- icode  input  4  instruction code of the instruction in decode.
- Cnd    input  1  condition result for conditional moves; 1 = move taken.
- rA     input  4  rA field of the instruction.
- rB     input  4  rB field of the instruction.
- srcA   output 4  register-file read address A, registered.
- srcB   output 4  register-file read address B, registered.
- destM  output 4  destination ID for the memory-result write, registered.
- destE  output 4  destination ID for the ALU-result write, registered.

Behaviour:
- Icode encoding:
  - 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq;
  - 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq;
  - C–F are invalid.
- Combinational next values, computed from the current inputs:
  - srcA_n = rA for icode 2, 4, 6, A; RRSP for 9, B; otherwise RNONE.
  - srcB_n = rB for icode 4, 5, 6; RRSP for 8, 9, A, B; otherwise RNONE.
  - destE_n:
    - icode 2: rB when Cnd=1, RNONE when Cnd=0;
    - icode 3, 6: rB;
    - icode 8, 9, A, B: RRSP;
    - otherwise RNONE.
  - destM_n = rA for icode 5, B; otherwise RNONE.
- Register update on each rising edge of clock:
  - reset=1: srcA, srcB, destM, destE <= RNONE.
  - Otherwise all four outputs load their *_n values.
- Latency: exactly one cycle. Outputs reflect the inputs sampled at the previous rising edge.
- Reset mid-operation: takes effect at the next edge and overrides all inputs. The first post-reset edge with reset=0 loads the current inputs normally.
- Pass-through: rA/rB are passed through unchanged even when equal to RNONE or to RRSP. No validity check is made on register fields.
- Invalid icode (C–F), halt (0), nop (1), jXX (7): all four outputs RNONE.
- Cnd is ignored for every icode except 2.
- popq (B): destE=RRSP and destM=rA are both produced. Write-back ordering when rA=RRSP is the responsibility of the write-back stage.
- No other state; no X propagation. Inputs are treated as 2-state.

Test Plan:
- reset=1 for one edge, with icode=B, rA=2, rB=7 applied -> after the edge all outputs = F.
- Reset released; icode=B, rA=2, rB=7, Cnd=0; clock four cycles -> from the first edge and on every later edge: srcA=4, srcB=4, destE=4, destM=2.
- icode=2, rA=3, rB=5:
  - Cnd=1 -> srcA=3, srcB=F, destE=5, destM=F;
  - Cnd=0 -> destE=F, others unchanged.
- Opcode sweep:
  - icode=6, rA=1, rB=2 -> srcA=1, srcB=2, destE=2, destM=F.
  - icode=5, rA=6, rB=7 -> srcA=F, srcB=7, destE=F, destM=6.
  - icode=A, rA=9 -> srcA=9, srcB=4, destE=4, destM=F.
- Invalid and non-register opcodes: icode in {0,1,7,C,D,E,F} with rA=1, rB=2 -> all outputs F one cycle later.
- Latency check: change icode from 3 to 8 between edges -> outputs switch only at the next rising edge.
  - Before the edge (icode 3 values, rB=2): srcA=F, srcB=F, destE=2, destM=F.
  - After the edge (icode 8 values): srcA=F, srcB=4, destE=4, destM=F.
